// File: rtl/llc_req_in_rr_mux.sv
// llc_req_in_rr_mux: N-channel request ingress for llc_core.
// Each channel has its own FIFO. A round-robin arbiter merges the FIFOs into
// one registered output stage, and that stage is tagged with the source channel.
// Optional feature macro: LLC_REQ_MUX_STATS_EN adds per-channel saturating
// grant counters and a stats_clr input.
module llc_req_in_rr_mux #(
    parameter  int NUM_CH = 4,
    parameter  int DEPTH  = 4,
    parameter  int REQ_W  = 64,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic [NUM_CH*REQ_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [REQ_W-1:0]        out_data,
    output logic [CH_W-1:0]         out_ch,
    output logic [NUM_CH-1:0]       fifo_empty
`ifdef LLC_REQ_MUX_STATS_EN
    ,
    input  logic                    stats_clr,
    output logic [NUM_CH*16-1:0]    stats_grant_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);   // FIFO address bits
    localparam int PW = AW + 1;          // pointer bits; the extra MSB tells full from empty

    // FIFO storage and pointers
    logic [REQ_W-1:0] r_mem    [NUM_CH][DEPTH];
    logic [PW-1:0]    r_wr_ptr [NUM_CH];
    logic [PW-1:0]    r_rd_ptr [NUM_CH];

    // Per-channel status and handshakes
    logic [NUM_CH-1:0] w_empty;
    logic [NUM_CH-1:0] w_full;
    logic [NUM_CH-1:0] w_push;
    logic [NUM_CH-1:0] w_pop;
    logic [REQ_W-1:0]  w_head [NUM_CH];

    // Arbiter and output stage
    logic [CH_W-1:0]   r_rr_ptr;
    logic [CH_W-1:0]   w_grant;
    logic              w_any;
    logic              w_load;
    logic              r_out_valid;
    logic [REQ_W-1:0]  r_out_data;
    logic [CH_W-1:0]   r_out_ch;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign w_empty[c]  = (r_wr_ptr[c] == r_rd_ptr[c]);
        assign w_full[c]   = (r_wr_ptr[c][AW] != r_rd_ptr[c][AW]) &&
                             (r_wr_ptr[c][AW-1:0] == r_rd_ptr[c][AW-1:0]);
        // A full FIFO refuses input even when it is popped in the same cycle,
        // so in_ready never depends on the arbiter (no combinational path to out_ready).
        assign in_ready[c] = !rst && !w_full[c];
        assign w_push[c]   = in_valid[c] && in_ready[c];
        assign w_pop[c]    = w_load && (w_grant == CH_W'(c));
        assign w_head[c]   = r_mem[c][r_rd_ptr[c][AW-1:0]];

        // Advance the FIFO pointers on push and pop. The pointers wrap naturally.
        // NOTE: Sequential state uses non-blocking (<=) so every flop samples pre-edge values.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_wr_ptr[c] <= '0;
                r_rd_ptr[c] <= '0;
            end else begin
                if (w_push[c]) r_wr_ptr[c] <= r_wr_ptr[c] + PW'(1);
                if (w_pop[c])  r_rd_ptr[c] <= r_rd_ptr[c] + PW'(1);
            end
        end

        // Write the payload into the FIFO slot.
        // NOTE: Storage is deliberately not reset; the cleared pointers make stale slots unreachable.
        always_ff @(posedge clk) begin
            if (w_push[c]) r_mem[c][r_wr_ptr[c][AW-1:0]] <= in_data[c*REQ_W +: REQ_W];
        end
    end

    assign fifo_empty = w_empty;

    // Search from the RR pointer upward with wrap-around. The first non-empty FIFO wins.
    // NOTE: Every always_comb output gets a default first, so no latch can be inferred.
    always_comb begin
        int              idx;
        logic [CH_W-1:0] v_idx;
        w_grant = '0;
        w_any   = 1'b0;
        idx     = 0;
        v_idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(r_rr_ptr) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            v_idx = CH_W'(idx);
            if (!w_any && !w_empty[v_idx]) begin
                w_any   = 1'b1;
                w_grant = v_idx;
            end
        end
    end

    // The output stage reloads when it is empty or being drained. While stalled it is frozen.
    assign w_load = (!r_out_valid || out_ready) && w_any;

    // Move the RR pointer past the granted channel. It holds when nothing is granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_load) begin
            r_rr_ptr <= (w_grant == CH_W'(NUM_CH - 1)) ? '0 : w_grant + CH_W'(1);
        end
    end

    // Registered merged output, tagged with its source channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_head[w_grant];
            r_out_ch    <= w_grant;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;

`ifdef LLC_REQ_MUX_STATS_EN
    logic [15:0] r_grant_cnt [NUM_CH];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_stats
        // Count loads from channel c. The counter saturates, and a clear beats a same-cycle increment.
        always_ff @(posedge clk) begin
            if (rst || stats_clr) begin
                r_grant_cnt[c] <= '0;
            end else if (w_pop[c] && (r_grant_cnt[c] != 16'hFFFF)) begin
                r_grant_cnt[c] <= r_grant_cnt[c] + 16'd1;
            end
        end
        assign stats_grant_cnt[c*16 +: 16] = r_grant_cnt[c];
    end
`endif

endmodule

// File: tb/tb_llc_req_in_rr_mux.sv
// Directed bench for llc_req_in_rr_mux. The stimulus pushes hand-ordered expected
// outputs into a scoreboard queue. A negedge monitor pops an entry and compares it
// on every accepted output beat.
module tb_llc_req_in_rr_mux;

    localparam int NUM_CH = 4;
    localparam int DEPTH  = 4;
    localparam int REQ_W  = 64;
    localparam int CH_W   = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_CH-1:0]       in_valid;
    logic [NUM_CH-1:0]       in_ready;
    logic [NUM_CH*REQ_W-1:0] in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [REQ_W-1:0]        out_data;
    logic [CH_W-1:0]         out_ch;
    logic [NUM_CH-1:0]       fifo_empty;
`ifdef LLC_REQ_MUX_STATS_EN
    logic                    stats_clr;
    logic [NUM_CH*16-1:0]    stats_grant_cnt;
`endif

    llc_req_in_rr_mux #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .REQ_W(REQ_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ch     (out_ch),
        .fifo_empty (fifo_empty)
`ifdef LLC_REQ_MUX_STATS_EN
        ,
        .stats_clr       (stats_clr),
        .stats_grant_cnt (stats_grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CH_W-1:0]  ch;
        logic [REQ_W-1:0] data;
    } exp_t;

    exp_t sb_q[$];
    bit   sb_en  = 1'b1;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_out(input int ch, input logic [REQ_W-1:0] d);
        exp_t e;
        e.ch   = CH_W'(ch);
        e.data = d;
        sb_q.push_back(e);
    endtask

    // Scoreboard monitor: every beat that will be accepted at the next posedge is compared here.
    always @(negedge clk) begin
        if (sb_en && rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got ch=%0d data=%0h, expected no output", out_ch, out_data);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_ch", 128'(out_ch), 128'(e.ch));
                check("sb_data", 128'(out_data), 128'(e.data));
            end
        end
    end

    // Drive inputs 1ns after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int ch, input logic [REQ_W-1:0] d);
        in_data[ch*REQ_W +: REQ_W] = d;
    endtask

    task automatic push1(input int ch, input logic [REQ_W-1:0] d);
        in_valid     = '0;
        in_valid[ch] = 1'b1;
        set_data(ch, d);
        tick();
        in_valid = '0;
    endtask

    task automatic do_reset(input int n);
        rst       = 1'b1;
        in_valid  = '0;
        out_ready = 1'b0;
        sb_q.delete();
        repeat (n) tick();
        rst = 1'b0;
    endtask

    // Wait, within a bounded number of cycles, until the scoreboard queue is empty.
    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check(name, 128'(sb_q.size()), 128'd0);
        tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
`ifdef LLC_REQ_MUX_STATS_EN
        stats_clr = 1'b0;
`endif

        // 1: reset for 3 cycles
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_in_ready_low", 128'(in_ready), 128'h0);
        end
        check("rst_out_valid", 128'(out_valid), 128'h0);
        check("rst_fifo_empty", 128'(fifo_empty), 128'hF);
        check("rst_out_data", 128'(out_data), 128'h0);
        check("rst_out_ch", 128'(out_ch), 128'h0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 128'(in_ready), 128'hF);

        // 2: single push on ch2; 1-cycle latency, then idle
        out_ready = 1'b1;
        expect_out(2, 64'hA5);
        push1(2, 64'hA5);
        check("lat_out_valid_t0", 128'(out_valid), 128'h0);
        tick();
        check("lat_out_valid_t1", 128'(out_valid), 128'h1);
        check("lat_out_data", 128'(out_data), 128'hA5);
        check("lat_out_ch", 128'(out_ch), 128'h2);
        tick();
        check("lat_out_valid_t2", 128'(out_valid), 128'h0);

        // 3: every channel holds 2 entries; round-robin order 0,1,2,3,0,1,2,3
        do_reset(2);
        for (int r = 0; r < 2; r++) begin
            in_valid = 4'hF;
            for (int c = 0; c < NUM_CH; c++) set_data(c, 64'h300 + 64'(c * 16 + r));
            tick();
        end
        in_valid = '0;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < NUM_CH; c++) expect_out(c, 64'h300 + 64'(c * 16 + r));
        check("rr_first_ch", 128'(out_ch), 128'h0);
        check("rr_first_data", 128'(out_data), 128'h300);
        out_ready = 1'b1;
        drain("rr_drain", 20);
        check("rr_idle_valid", 128'(out_valid), 128'h0);
        check("rr_idle_empty", 128'(fifo_empty), 128'hF);

        // 4: ch1 fills while the output is stalled; the 5th push is refused
        do_reset(2);
        expect_out(0, 64'hB0);
        push1(0, 64'hB0);
        tick();
        for (int k = 0; k < 5; k++) begin
            check("full_in_ready1", 128'(in_ready[1]), (k < 4) ? 128'h1 : 128'h0);
            if (k < 4) expect_out(1, 64'h410 + 64'(k));
            in_valid[1] = 1'b1;
            set_data(1, 64'h410 + 64'(k));
            tick();
        end
        in_valid = '0;
        check("full_fifo_empty", 128'(fifo_empty), 128'hD);
        out_ready = 1'b1;
        tick();
        check("full_in_ready_back", 128'(in_ready[1]), 128'h1);
        check("full_first_pop_ch", 128'(out_ch), 128'h1);
        drain("full_drain", 20);

        // 5: the output stalls for 10 cycles while ch0/ch3 fill; it must stay frozen
        do_reset(2);
        expect_out(2, 64'h5A);
        push1(2, 64'h5A);
        tick();
        for (int k = 0; k < 10; k++) begin
            in_valid = '0;
            if (k < 4) begin
                in_valid = 4'b1001;
                set_data(0, 64'h500 + 64'(k));
                set_data(3, 64'h530 + 64'(k));
            end
            tick();
            check("stall_valid", 128'(out_valid), 128'h1);
            check("stall_data", 128'(out_data), 128'h5A);
            check("stall_ch", 128'(out_ch), 128'h2);
        end
        in_valid = '0;
        check("stall_in_ready", 128'(in_ready), 128'h6);
        for (int k = 0; k < 4; k++) begin
            expect_out(3, 64'h530 + 64'(k));
            expect_out(0, 64'h500 + 64'(k));
        end
        out_ready = 1'b1;
        drain("stall_drain", 30);

        // 6: reset mid-operation drops everything and returns the RR pointer to 0
        out_ready = 1'b0;
        push1(1, 64'h61);
        push1(1, 64'h62);
        tick();
        check("midrst_pre_valid", 128'(out_valid), 128'h1);
        do_reset(1);
        check("midrst_out_valid", 128'(out_valid), 128'h0);
        check("midrst_fifo_empty", 128'(fifo_empty), 128'hF);
        #1;
        check("midrst_in_ready", 128'(in_ready), 128'hF);
        expect_out(0, 64'h70);
        expect_out(3, 64'h73);
        in_valid = 4'b1001;
        set_data(0, 64'h70);
        set_data(3, 64'h73);
        out_ready = 1'b1;
        tick();
        in_valid = '0;
        drain("midrst_drain", 20);

`ifdef LLC_REQ_MUX_STATS_EN
        // 7: the ch0 grant counter saturates and is cleared by stats_clr
        do_reset(2);
        sb_en       = 1'b0;
        out_ready   = 1'b1;
        in_valid[0] = 1'b1;
        set_data(0, 64'hC0);
        repeat (70000) tick();
        in_valid = '0;
        repeat (3) tick();
        check("stats_sat_ch0", 128'(stats_grant_cnt[15:0]), 128'hFFFF);
        check("stats_ch1_zero", 128'(stats_grant_cnt[31:16]), 128'h0);
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        check("stats_clr", 128'(stats_grant_cnt[15:0]), 128'h0);
        sb_en = 1'b1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
